// File: rtl/prog_loader_pkg.sv
// Shared types and stream constants for the program loader.
// LOADER_CHECKSUM_EN adds the per-section checksum state.
package prog_loader_pkg;

   typedef enum logic [2:0] {
      StHdr,
      StLenLo,
      StLenHi,
      StPayload,
`ifdef LOADER_CHECKSUM_EN
      StCsum,
`endif
      StDone,
      StErr
   } state_e;

   localparam logic [7:0] HDR_INST = 8'h00;
   localparam logic [7:0] HDR_DATA = 8'h01;
   localparam logic [7:0] HDR_END  = 8'hFF;

endpackage

// File: rtl/prog_loader_pack.sv
// Byte-to-word assembler: packs four bytes little-endian and pulses word_vld_o
// the cycle after the fourth byte.
module prog_loader_pack (
   input  logic        CLK,
   input  logic        RST,
   input  logic        byte_en_i,
   input  logic [7:0]  byte_i,
   output logic [1:0]  lane_o,
   output logic [31:0] word_o,
   output logic        word_vld_o
);

   logic [1:0]  lane_q, lane_d;
   logic [31:0] word_q, word_d;
   logic        vld_q, vld_d;

   always_comb begin
      lane_d = lane_q;
      word_d = word_q;
      vld_d  = 1'b0;
      if (byte_en_i) begin
         unique case (lane_q)
            2'd0: word_d[7:0]   = byte_i;
            2'd1: word_d[15:8]  = byte_i;
            2'd2: word_d[23:16] = byte_i;
            2'd3: word_d[31:24] = byte_i;
            default: ;
         endcase
         lane_d = lane_q + 2'd1;
         vld_d  = (lane_q == 2'd3);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         lane_q <= 2'd0;
         word_q <= 32'd0;
         vld_q  <= 1'b0;
      end else begin
         lane_q <= lane_d;
         word_q <= word_d;
         vld_q  <= vld_d;
      end
   end

   assign lane_o     = lane_q;
   assign word_o     = word_q;
   assign word_vld_o = vld_q;

endmodule

// File: rtl/prog_loader.sv
// Streams sectioned program/data images into instruction and data memories,
// holding the core in reset until the end marker. Option: LOADER_CHECKSUM_EN.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int unsigned INST_WORDS = 32,
   parameter int unsigned DATA_BYTES = 64
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          in_valid,
   input  logic [7:0]                    in_data,
   output logic                          in_ready,
   output logic                          inst_we,
   output logic [$clog2(INST_WORDS)-1:0] inst_addr,
   output logic [31:0]                   inst_wdata,
   output logic                          data_we,
   output logic [$clog2(DATA_BYTES)-1:0] data_addr,
   output logic [7:0]                    data_wdata,
   output logic                          core_rst,
   output logic                          done,
   output logic                          err
);

   localparam int unsigned IAW = $clog2(INST_WORDS);
   localparam int unsigned DAW = $clog2(DATA_BYTES);
   localparam int unsigned IPW = IAW + 1;
   localparam int unsigned DPW = DAW + 1;
   localparam logic [IPW-1:0] INST_LIM = IPW'(INST_WORDS);
   localparam logic [DPW-1:0] DATA_LIM = DPW'(DATA_BYTES);

`ifdef LOADER_CHECKSUM_EN
   localparam state_e SECT_END = StCsum;
`else
   localparam state_e SECT_END = StHdr;
`endif

   state_e         state_q, state_d;
   logic           is_inst_q, is_inst_d;
   logic [7:0]     len_lo_q, len_lo_d;
   logic [15:0]    cnt_q, cnt_d;
   logic [IPW-1:0] iptr_q, iptr_d;
   logic [DPW-1:0] dptr_q, dptr_d;
   logic [IAW-1:0] iaddr_q, iaddr_d;
   logic           dwe_q, dwe_d;
   logic [DAW-1:0] daddr_q, daddr_d;
   logic [7:0]     dwdata_q, dwdata_d;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]     csum_q, csum_d;
`endif

   logic        accept;
   logic        ovf;
   logic [15:0] len;
   logic        pack_en;
   logic [1:0]  pack_lane;

   prog_loader_pack u_pack (
      .CLK        (CLK),
      .RST        (RST),
      .byte_en_i  (pack_en),
      .byte_i     (in_data),
      .lane_o     (pack_lane),
      .word_o     (inst_wdata),
      .word_vld_o (inst_we)
   );

   always_comb begin
      in_ready = 1'b0;
      if (!RST) begin
         unique case (state_q)
            StDone, StErr: in_ready = 1'b0;
            default:       in_ready = 1'b1;
         endcase
      end
   end

   assign accept = in_valid & in_ready;
   assign len    = {in_data, len_lo_q};

   always_comb begin
      state_d   = state_q;
      is_inst_d = is_inst_q;
      len_lo_d  = len_lo_q;
      cnt_d     = cnt_q;
      iptr_d    = iptr_q;
      dptr_d    = dptr_q;
      iaddr_d   = iaddr_q;
      dwe_d     = 1'b0;
      daddr_d   = daddr_q;
      dwdata_d  = dwdata_q;
`ifdef LOADER_CHECKSUM_EN
      csum_d    = csum_q;
`endif
      ovf       = 1'b0;
      pack_en   = 1'b0;
      if (accept) begin
         unique case (state_q)
            StHdr: begin
               case (in_data)
                  HDR_INST: begin
                     is_inst_d = 1'b1;
                     state_d   = StLenLo;
                  end
                  HDR_DATA: begin
                     is_inst_d = 1'b0;
                     state_d   = StLenLo;
                  end
                  HDR_END: state_d = StDone;
                  default: state_d = StErr;
               endcase
            end
            StLenLo: begin
               len_lo_d = in_data;
               state_d  = StLenHi;
            end
            StLenHi: begin
               cnt_d = len;
`ifdef LOADER_CHECKSUM_EN
               csum_d = 8'd0;
`endif
               if (is_inst_q && (len[1:0] != 2'd0)) begin
                  state_d = StErr;
               end else if (len == 16'd0) begin
                  state_d = SECT_END;
               end else begin
                  state_d = StPayload;
               end
            end
            StPayload: begin
               // An instruction word only overflows when its final byte would commit it.
               if (is_inst_q) begin
                  ovf = (pack_lane == 2'd3) && (iptr_q >= INST_LIM);
               end else begin
                  ovf = (dptr_q >= DATA_LIM);
               end
               if (ovf) begin
                  state_d = StErr;
               end else begin
                  if (is_inst_q) begin
                     pack_en = 1'b1;
                     if (pack_lane == 2'd3) begin
                        iaddr_d = iptr_q[IAW-1:0];
                        iptr_d  = iptr_q + IPW'(1);
                     end
                  end else begin
                     dwe_d    = 1'b1;
                     daddr_d  = dptr_q[DAW-1:0];
                     dwdata_d = in_data;
                     dptr_d   = dptr_q + DPW'(1);
                  end
`ifdef LOADER_CHECKSUM_EN
                  csum_d = csum_q ^ in_data;
`endif
                  cnt_d = cnt_q - 16'd1;
                  if (cnt_q == 16'd1) state_d = SECT_END;
               end
            end
`ifdef LOADER_CHECKSUM_EN
            StCsum: state_d = (in_data == csum_q) ? StHdr : StErr;
`endif
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= StHdr;
         is_inst_q <= 1'b0;
         len_lo_q  <= 8'd0;
         cnt_q     <= 16'd0;
         iptr_q    <= '0;
         dptr_q    <= '0;
         iaddr_q   <= '0;
         dwe_q     <= 1'b0;
         daddr_q   <= '0;
         dwdata_q  <= 8'd0;
`ifdef LOADER_CHECKSUM_EN
         csum_q    <= 8'd0;
`endif
      end else begin
         state_q   <= state_d;
         is_inst_q <= is_inst_d;
         len_lo_q  <= len_lo_d;
         cnt_q     <= cnt_d;
         iptr_q    <= iptr_d;
         dptr_q    <= dptr_d;
         iaddr_q   <= iaddr_d;
         dwe_q     <= dwe_d;
         daddr_q   <= daddr_d;
         dwdata_q  <= dwdata_d;
`ifdef LOADER_CHECKSUM_EN
         csum_q    <= csum_d;
`endif
      end
   end

   assign inst_addr  = iaddr_q;
   assign data_we    = dwe_q;
   assign data_addr  = daddr_q;
   assign data_wdata = dwdata_q;
   assign done       = (state_q == StDone);
   assign err        = (state_q == StErr);
   assign core_rst   = ~done;

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter INST_WORDS, default 32: instruction memory depth in 32-bit words.
REQ-002 Parameter DATA_BYTES, default 64: data memory depth in bytes.
REQ-003 CLK  input  1  single clock, all state updates on its rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream byte valid.
REQ-006 in_data  input  8  upstream byte.
REQ-007 in_ready  output  1  loader accepts byte; transfer = in_valid & in_ready on a CLK edge.
REQ-008 inst_we / inst_addr / inst_wdata  output  1 / $clog2(INST_WORDS) / 32  instruction-memory write port (word index).
REQ-009 data_we / data_addr / data_wdata  output  1 / $clog2(DATA_BYTES) / 8  data-memory byte write port.
REQ-010 core_rst  output  1  holds the single-cycle core in reset until load completes.
REQ-011 done  output  1  load finished successfully (sticky).
REQ-012 err  output  1  protocol error (sticky).

Function
REQ-013 Stream format: section = header byte, LEN_LO, LEN_HI (16-bit byte count N, little-endian), N payload bytes; header 0x00 = instruction section, 0x01 = data section, 0xFF = end of stream, any other value = error.
REQ-014 FSM states HDR, LEN_LO, LEN_HI, PAYLOAD, CSUM, DONE, ERR; each accepted byte advances per REQ-013; N=0 skips PAYLOAD.
REQ-015 in_ready = 1 in HDR, LEN_LO, LEN_HI, PAYLOAD, CSUM; 0 in DONE, ERR and during the reset cycle.
REQ-016 Instruction payload: bytes packed little-endian into a 32-bit word (first byte -> bits 7:0); inst_we pulses exactly one cycle, the cycle after the 4th byte is accepted.
REQ-017 Data payload: each accepted byte produces a one-cycle data_we pulse the following cycle, data_wdata = that byte.
REQ-018 Write pointers (inst word, data byte) start at 0 after reset and persist across sections, so repeated sections of the same type append.
REQ-019 Instruction section with N not a multiple of 4 -> ERR at the LEN_HI byte.
REQ-020 Write that would exceed INST_WORDS or DATA_BYTES -> ERR on the offending byte, no write issued.
REQ-021 Header 0xFF -> DONE next cycle: done=1, core_rst=0 on that same cycle.
REQ-022 ERR: err=1, core_rst stays 1, no further writes; exit only via RST.
REQ-023 in_valid low stalls the FSM with no state change and no writes; a partial instruction word is held across stalls.

Reset
REQ-024 RST sampled high: state HDR, pointers 0, byte lane counter 0, inst_we=0, data_we=0, all addr/wdata=0, done=0, err=0, core_rst=1, in_ready=0.
REQ-025 RST mid-section abandons the section; already-written memory contents are not cleared.

Configuration
REQ-026 Macro LOADER_CHECKSUM_EN defined: every section except the end marker carries one extra byte after the payload (state CSUM) equal to XOR of all payload bytes; mismatch -> ERR; match -> HDR.
REQ-027 Macro undefined: no CSUM state, PAYLOAD (or LEN_HI when N=0) returns directly to HDR.

Structure
REQ-028 Shared package holds the FSM state enum and header constants (HDR_INST=8'h00, HDR_DATA=8'h01, HDR_END=8'hFF).
REQ-029 One sub-module prog_loader_pack: byte-to-32-bit little-endian word assembler with lane counter and word-ready pulse.

Verification
REQ-030 Bytes 00 08 00, then 93 00 50 00 13 01 A0 00, then FF -> inst_we at word 0 = 0x00500093, word 1 = 0x00A00113; done=1, core_rst=0.
REQ-031 Bytes 01 03 00 AA BB CC, then FF -> data_we at addresses 0,1,2 with AA,BB,CC; no inst_we.
REQ-032 Header 00 with N=6 -> err=1 after LEN_HI, in_ready=0, core_rst=1, no writes.
REQ-033 Data section N=DATA_BYTES+1 -> DATA_BYTES writes then err=1 on the last byte.
REQ-034 in_valid toggled 1/0 every cycle during REQ-030 stream -> identical writes, stalled cycles produce none; RST asserted after the 5th payload byte -> state HDR, core_rst=1, restart reloads word 0.
REQ-035 With LOADER_CHECKSUM_EN: section 01 02 00 12 34 with checksum 26 -> back to HDR; checksum 27 -> err=1.
